// File: rtl/cheby_coeff_loader.sv
// Double-buffered Chebyshev coefficient store: loads a serial BF16 stream into the
// inactive bank and commits it atomically by bank swap; four combinational read ports.
module cheby_coeff_loader #(
  parameter int unsigned SEGMENTS = 128,
  parameter int unsigned TERMS    = 4,
  parameter int unsigned WIDTH    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load_start,
  input  logic                        load_abort,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [WIDTH-1:0]            s_data,
  input  logic                        s_last,
  input  logic                        swap_en,
  input  logic [$clog2(SEGMENTS)-1:0] rd_idx0,
  input  logic [$clog2(SEGMENTS)-1:0] rd_idx1,
  input  logic [$clog2(SEGMENTS)-1:0] rd_idx2,
  input  logic [$clog2(SEGMENTS)-1:0] rd_idx3,
  output logic [WIDTH-1:0]            rd_coef0,
  output logic [WIDTH-1:0]            rd_coef1,
  output logic [WIDTH-1:0]            rd_coef2,
  output logic [WIDTH-1:0]            rd_coef3,
  output logic                        busy,
  output logic                        load_done,
  output logic                        load_err,
  output logic                        coef_valid
);

  localparam int unsigned IW    = $clog2(SEGMENTS);
  localparam int unsigned WORDS = TERMS * SEGMENTS;
  localparam int unsigned CW    = $clog2(WORDS);
  localparam int unsigned TW    = (TERMS > 1) ? $clog2(TERMS) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StPend = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic          active_q, active_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          cv_q, cv_d;
  logic          we;
  logic          last_word;
  logic [TW-1:0] wr_term;
  logic [IW-1:0] wr_seg;

  // Bank contents are deliberately not reset.
  logic [WIDTH-1:0] mem [2][TERMS][SEGMENTS];

  assign last_word = (wcnt_q == CW'(WORDS - 1));
  // Segment-major, term-minor stream order.
  assign wr_term   = TW'(wcnt_q % CW'(TERMS));
  assign wr_seg    = IW'(wcnt_q / CW'(TERMS));

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    active_d = active_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    cv_d     = cv_q;
    we       = 1'b0;
    case (state_q)
      StIdle: begin
        if (load_start) begin
          wcnt_d  = '0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (load_abort) begin
          state_d = StIdle;
        end else if (s_valid) begin
          if (last_word && s_last) begin
            we      = 1'b1;
            state_d = StPend;
          end else if (last_word || s_last) begin
            // Framing error: drop the word, keep the active bank.
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            we     = 1'b1;
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      StPend: begin
        if (load_abort) begin
          state_d = StIdle;
        end else if (swap_en) begin
          active_d = ~active_q;
          done_d   = 1'b1;
          cv_d     = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      wcnt_q   <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      cv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      active_q <= active_d;
      done_q   <= done_d;
      err_q    <= err_d;
      cv_q     <= cv_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[~active_q][wr_term][wr_seg] <= s_data;
    end
  end

  assign rd_coef0   = mem[active_q][0][rd_idx0];
  assign rd_coef1   = mem[active_q][1][rd_idx1];
  assign rd_coef2   = mem[active_q][2][rd_idx2];
  assign rd_coef3   = mem[active_q][3][rd_idx3];

  assign s_ready    = (state_q == StLoad);
  assign busy       = (state_q != StIdle);
  assign load_done  = done_q;
  assign load_err   = err_q;
  assign coef_valid = cv_q;

endmodule

// File: tb/tb_cheby_coeff_loader.sv
// Randomized scoreboard bench for cheby_coeff_loader: a word-indexed table model
// predicts reads, and expected done/err pulses are queued for an independent monitor.
module tb_cheby_coeff_loader;

  localparam int SEG   = 128;
  localparam int TRM   = 4;
  localparam int WORDS = SEG * TRM;
  localparam logic [1:0] EvDone = 2'b10;
  localparam logic [1:0] EvErr  = 2'b01;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_start = 1'b0, load_abort = 1'b0;
  logic        s_valid = 1'b0, s_last = 1'b0, swap_en = 1'b0;
  logic        s_ready;
  logic [15:0] s_data = '0;
  logic [6:0]  rd_idx0 = '0, rd_idx1 = '0, rd_idx2 = '0, rd_idx3 = '0;
  logic [15:0] rd_coef0, rd_coef1, rd_coef2, rd_coef3;
  logic        busy, load_done, load_err, coef_valid;

  int checks = 0;
  int failures = 0;

  logic [1:0]  expq[$];
  logic [15:0] act_tab[WORDS];
  logic [15:0] pend_tab[WORDS];

  cheby_coeff_loader #(.SEGMENTS(SEG), .TERMS(TRM), .WIDTH(16)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_abort(load_abort),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .swap_en(swap_en),
    .rd_idx0(rd_idx0), .rd_idx1(rd_idx1), .rd_idx2(rd_idx2), .rd_idx3(rd_idx3),
    .rd_coef0(rd_coef0), .rd_coef1(rd_coef1), .rd_coef2(rd_coef2), .rd_coef3(rd_coef3),
    .busy(busy), .load_done(load_done), .load_err(load_err), .coef_valid(coef_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every pulse the DUT raises must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst && (load_done || load_err)) begin
      checks++;
      if (expq.size() == 0) begin
        failures++;
        $display("FAIL pulse_unexpected: got done=%0b err=%0b expected none", load_done,
                 load_err);
      end else begin
        logic [1:0] e;
        e = expq.pop_front();
        if ({load_done, load_err} !== e) begin
          failures++;
          $display("FAIL pulse_kind: got %02b expected %02b", {load_done, load_err}, e);
        end
      end
    end
  end

  task automatic check_reads(input int n);
    int ix[4];
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) ix[k] = $urandom_range(0, SEG - 1);
      rd_idx0 = 7'(ix[0]);
      rd_idx1 = 7'(ix[1]);
      rd_idx2 = 7'(ix[2]);
      rd_idx3 = 7'(ix[3]);
      #1;
      chk("rd_coef0", {16'h0, rd_coef0}, {16'h0, act_tab[ix[0] * TRM + 0]});
      chk("rd_coef1", {16'h0, rd_coef1}, {16'h0, act_tab[ix[1] * TRM + 1]});
      chk("rd_coef2", {16'h0, rd_coef2}, {16'h0, act_tab[ix[2] * TRM + 2]});
      chk("rd_coef3", {16'h0, rd_coef3}, {16'h0, act_tab[ix[3] * TRM + 3]});
    end
  endtask

  // mode: 0 -> n, 1 -> n+0x1000, 2 -> random. bad_at flips s_last on that word.
  task automatic do_load(input int mode, input int bad_at, input int abort_at, input bit gaps,
                         input bit hold);
    bit ok;
    logic [15:0] v;
    ok = 1'b0;
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    chk("ready_after_start", {31'h0, s_ready}, 32'h1);
    for (int n = 0; n < WORDS; n++) begin
      if (gaps) begin
        while ($urandom_range(0, 1) == 1) begin
          s_valid = 1'b0;
          @(negedge clk);
        end
      end
      v = (mode == 0) ? 16'(n) : (mode == 1) ? 16'(n + 'h1000) : 16'($urandom);
      if (n == abort_at) begin
        s_valid    = 1'b0;
        load_abort = 1'b1;
        @(negedge clk);
        load_abort = 1'b0;
        chk("busy_after_abort", {31'h0, busy}, 32'h0);
        break;
      end
      s_valid    = 1'b1;
      s_data     = v;
      s_last     = (n == WORDS - 1) ^ (n == bad_at);
      load_start = (n == 10);  // must be ignored mid-load
      if (n == bad_at) expq.push_back(EvErr);
      else pend_tab[n] = v;
      if (n == WORDS - 1 && n != bad_at && !hold) begin
        swap_en = 1'b1;
        expq.push_back(EvDone);
      end
      @(negedge clk);
      s_valid    = 1'b0;
      s_last     = 1'b0;
      load_start = 1'b0;
      if (n == bad_at) begin
        chk("busy_after_err", {31'h0, busy}, 32'h0);
        break;
      end
      if (n == WORDS - 1) ok = 1'b1;
    end
    if (ok) begin
      if (hold) begin
        rd_idx2 = 7'd5;
        for (int c = 0; c < 10; c++) begin
          #1;
          chk("pend_busy", {31'h0, busy}, 32'h1);
          chk("pend_ready", {31'h0, s_ready}, 32'h0);
          chk("pend_old_coef2", {16'h0, rd_coef2}, {16'h0, act_tab[5 * TRM + 2]});
          @(negedge clk);
        end
        expq.push_back(EvDone);
        swap_en = 1'b1;
        @(negedge clk);
        swap_en = 1'b0;
      end else begin
        @(negedge clk);
        swap_en = 1'b0;
      end
      for (int i = 0; i < WORDS; i++) act_tab[i] = pend_tab[i];
      chk("busy_after_swap", {31'h0, busy}, 32'h0);
      chk("coef_valid_after_swap", {31'h0, coef_valid}, 32'h1);
    end
  endtask

  initial begin
    #1;
    chk("rst_s_ready", {31'h0, s_ready}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_load_done", {31'h0, load_done}, 32'h0);
    chk("rst_load_err", {31'h0, load_err}, 32'h0);
    chk("rst_coef_valid", {31'h0, coef_valid}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    do_load(0, -1, -1, 1'b0, 1'b0);
    rd_idx2 = 7'd5;
    #1;
    chk("first_table_coef2_5", {16'h0, rd_coef2}, 32'h0016);
    check_reads(8);

    do_load(1, -1, -1, 1'b0, 1'b1);
    rd_idx2 = 7'd5;
    #1;
    chk("second_table_coef2_5", {16'h0, rd_coef2}, 32'h1016);
    check_reads(8);

    do_load(2, 100, -1, 1'b0, 1'b0);
    check_reads(8);
    chk("coef_valid_after_err", {31'h0, coef_valid}, 32'h1);
    do_load(2, WORDS - 1, -1, 1'b0, 1'b0);
    check_reads(8);

    do_load(2, -1, 300, 1'b0, 1'b0);
    check_reads(8);
    do_load(2, -1, -1, 1'b0, 1'b0);
    check_reads(8);

    do_load(2, -1, -1, 1'b1, 1'b0);
    check_reads(16);

    // Asynchronous reset in the middle of a load.
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    for (int n = 0; n < 200; n++) begin
      s_valid = 1'b1;
      s_data  = 16'($urandom);
      @(negedge clk);
    end
    #2;
    rst = 1'b1;
    s_valid = 1'b0;
    #1;
    chk("midrst_s_ready", {31'h0, s_ready}, 32'h0);
    chk("midrst_busy", {31'h0, busy}, 32'h0);
    chk("midrst_coef_valid", {31'h0, coef_valid}, 32'h0);
    chk("midrst_load_done", {31'h0, load_done}, 32'h0);
    chk("midrst_load_err", {31'h0, load_err}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    do_load(2, -1, -1, 1'b0, 1'b0);
    check_reads(8);

    repeat (5) @(negedge clk);
    chk("pulses_all_seen", expq.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
